// File: rtl/game_pkg.sv
// Screen codes, objective hints and life limits shared by the game sequencer
// and the display path.
package game_pkg;

    typedef enum logic [3:0] {
        ST_TITLE    = 4'd0,
        ST_STAFF    = 4'd1,
        ST_STAGE1   = 4'd2,
        ST_SUCCESS1 = 4'd3,
        ST_STAGE2   = 4'd4,
        ST_SUCCESS2 = 4'd5,
        ST_STAGE3   = 4'd6,
        ST_SUCCESS3 = 4'd7,
        ST_FAIL     = 4'd8,
        ST_HELP     = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        TODO_FIND_KEYS = 2'd0,
        TODO_GO_DOOR   = 2'd1,
        TODO_BOSS      = 2'd2,
        TODO_NONE      = 2'd3
    } todo_t;

    localparam int LIFE_MAX = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic is_stage(input state_t s);
        return (s == ST_STAGE1) || (s == ST_STAGE2) || (s == ST_STAGE3);
    endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Event inputs from the input/collision logic and the game-state outputs
// consumed by game_display.
interface game_flow_ctrl_if;
    // Every event except at_door is a single-cycle pulse sampled on the rising
    // clock edge; at_door is a level; all outputs are registered.
    logic       frame_tick;
    logic       btn_start;
    logic       btn_help;
    logic       btn_back;
    logic       key_pickup;
    logic       player_hit;
    logic       at_door;
    logic       boss_defeated;
    logic [3:0] state;
    logic [1:0] life;
    logic [1:0] key_find;
    logic [1:0] todo;
    logic [3:0] play_valid;
    logic       isDark;

    modport master (
        output frame_tick, btn_start, btn_help, btn_back,
        output key_pickup, player_hit, at_door, boss_defeated,
        input  state, life, key_find, todo, play_valid, isDark
    );

    modport slave (
        input  frame_tick, btn_start, btn_help, btn_back,
        input  key_pickup, player_hit, at_door, boss_defeated,
        output state, life, key_find, todo, play_valid, isDark
    );
endinterface

// File: rtl/frame_timer.sv
// Loadable down-counter that steps once per video frame and rests at zero.
module frame_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         frame_tick,
    output logic [W-1:0] count,
    output logic         done
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (frame_tick && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: screen FSM, lives, keys, stage-clear mask and the frame-based
// hold, invulnerability and lights-off timers.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int SUCCESS_FRAMES = 180,
    parameter int FAIL_FRAMES    = 240,
    parameter int INVULN_FRAMES  = 60,
    parameter int DARK_PERIOD    = 120,
    parameter int LIFE_INIT      = 3
) (
    input logic             clk,
    input logic             rst_n,
    game_flow_ctrl_if.slave bus
);

    localparam int MAX_FRAMES = max_int(max_int(SUCCESS_FRAMES, FAIL_FRAMES),
                                        max_int(INVULN_FRAMES, DARK_PERIOD));
    localparam int CW         = $clog2(MAX_FRAMES) + 1;
    localparam int LIFE_LOAD  = (LIFE_INIT > LIFE_MAX) ? LIFE_MAX : LIFE_INIT;

    state_t        state_q, next_state;
    logic [1:0]    life_q, key_q, key_next, todo_q, todo_next;
    logic [3:0]    pv_q, pv_set;
    logic          is_dark_q, dark_next;
    logic          in_stage, entering, stage_entry, hit_ok, dark_tick_hit;

    logic          hold_load, hold_done;
    logic [CW-1:0] hold_val, unused_hold_count;
    logic          inv_load, inv_done;
    logic [CW-1:0] inv_val, unused_inv_count;
    logic          dark_load, dark_done;
    logic [CW-1:0] dark_val, dark_count;

    // Screen transitions; within a stage: FAIL > abort > exit.
    always_comb begin
        next_state = state_q;
        hit_ok     = 1'b0;
        case (state_q)
            ST_TITLE: begin
                if (bus.btn_start)     next_state = ST_STAGE1;
                else if (bus.btn_help) next_state = ST_HELP;
                else if (bus.btn_back) next_state = ST_STAFF;
            end
            ST_STAFF, ST_HELP: begin
                if (bus.btn_back) next_state = ST_TITLE;
            end
            ST_STAGE1, ST_STAGE2, ST_STAGE3: begin
                hit_ok = bus.player_hit && inv_done && (life_q != 2'd0);
                if (hit_ok && (life_q == 2'd1)) begin
                    next_state = ST_FAIL;
                end else if (bus.btn_back) begin
                    next_state = ST_TITLE;
                end else if (state_q == ST_STAGE3) begin
                    if (bus.boss_defeated) next_state = ST_SUCCESS3;
                end else if (bus.at_door && (key_q == 2'd3)) begin
                    next_state = (state_q == ST_STAGE1) ? ST_SUCCESS1 : ST_SUCCESS2;
                end
            end
            ST_SUCCESS1: if (hold_done || bus.btn_start) next_state = ST_STAGE2;
            ST_SUCCESS2: if (hold_done || bus.btn_start) next_state = ST_STAGE3;
            ST_SUCCESS3: if (hold_done || bus.btn_start) next_state = ST_TITLE;
            ST_FAIL:     if (hold_done) next_state = ST_TITLE;
            default:     next_state = ST_TITLE;
        endcase
    end

    always_comb begin
        in_stage    = is_stage(state_q);
        entering    = (next_state != state_q);
        stage_entry = entering && is_stage(next_state);

        hold_load = entering && (next_state inside {ST_SUCCESS1, ST_SUCCESS2,
                                                    ST_SUCCESS3, ST_FAIL});
        hold_val  = (next_state == ST_FAIL) ? CW'(FAIL_FRAMES) : CW'(SUCCESS_FRAMES);

        inv_load = stage_entry || hit_ok;
        inv_val  = hit_ok ? CW'(INVULN_FRAMES) : '0;

        // The dark timer re-arms itself on the tick that toggles the lights.
        dark_tick_hit = (state_q == ST_STAGE2) && bus.frame_tick && (dark_count == CW'(1));
        dark_load     = stage_entry || ((state_q == ST_STAGE2) && (dark_tick_hit || dark_done));
        dark_val      = (next_state == ST_STAGE2) ? CW'(DARK_PERIOD) : '0;
        dark_next     = ((next_state == ST_STAGE2) && !stage_entry) ?
                        (is_dark_q ^ dark_tick_hit) : 1'b0;

        pv_set = 4'b0000;
        if (entering) begin
            case (next_state)
                ST_SUCCESS1: pv_set = 4'b0010;
                ST_SUCCESS2: pv_set = 4'b0100;
                ST_SUCCESS3: pv_set = 4'b1000;
                default:     pv_set = 4'b0000;
            endcase
        end

        if (stage_entry)
            key_next = 2'd0;
        else if (in_stage && bus.key_pickup && (key_q != 2'd3))
            key_next = key_q + 2'd1;
        else
            key_next = key_q;

        case (next_state)
            ST_STAGE1, ST_STAGE2: todo_next = (key_next == 2'd3) ? TODO_GO_DOOR : TODO_FIND_KEYS;
            ST_STAGE3:            todo_next = TODO_BOSS;
            default:              todo_next = TODO_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_TITLE;
            life_q    <= 2'(LIFE_LOAD);
            key_q     <= 2'd0;
            pv_q      <= 4'b0001;
            is_dark_q <= 1'b0;
            todo_q    <= TODO_NONE;
        end else begin
            state_q <= next_state;
            if ((state_q == ST_TITLE) && bus.btn_start)
                life_q <= 2'(LIFE_LOAD);
            else if (hit_ok)
                life_q <= life_q - 2'd1;
            key_q     <= key_next;
            pv_q      <= pv_q | pv_set;
            is_dark_q <= dark_next;
            todo_q    <= todo_next;
        end
    end

    frame_timer #(.W(CW)) u_hold_timer (
        .clk(clk), .rst_n(rst_n), .load(hold_load), .load_val(hold_val),
        .frame_tick(bus.frame_tick), .count(unused_hold_count), .done(hold_done)
    );

    frame_timer #(.W(CW)) u_inv_timer (
        .clk(clk), .rst_n(rst_n), .load(inv_load), .load_val(inv_val),
        .frame_tick(bus.frame_tick), .count(unused_inv_count), .done(inv_done)
    );

    frame_timer #(.W(CW)) u_dark_timer (
        .clk(clk), .rst_n(rst_n), .load(dark_load), .load_val(dark_val),
        .frame_tick(bus.frame_tick), .count(dark_count), .done(dark_done)
    );

    assign bus.state      = state_q;
    assign bus.life       = life_q;
    assign bus.key_find   = key_q;
    assign bus.todo       = todo_q;
    assign bus.play_valid = pv_q;
    assign bus.isDark     = is_dark_q;

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Top-level game sequencer that drives the `state`, `life`, `key_find`, `todo`, `play_valid` and `isDark` inputs of `game_display`. It turns debounced button pulses and gameplay events into screen transitions. It tracks lives, keys, stage clears and invulnerability, and times the success and fail screens in video frames. It sits between the input/collision logic and the display path, and is the only writer of the game state.

## Interface
- `SUCCESS_FRAMES`, default 180: frames a SUCCESSn screen is held before auto-advance.
- `FAIL_FRAMES`, default 240: frames the FAIL screen is held before returning to TITLE.
- `INVULN_FRAMES`, default 60: frames of hit immunity after a life is lost.
- `DARK_PERIOD`, default 120: frames between `isDark` toggles in STAGE2.
- `LIFE_INIT`, default 3: lives loaded on a new game (range 1–3).

Ports:
- `clk` input 1: system clock. This block uses one clock only.
- `rst_n` input 1: reset. It is asynchronous and active-low.
- `frame_tick` input 1: single-cycle pulse, once per video frame (vsync).
- `btn_start` input 1: single-cycle pulse.
- `btn_help` input 1: single-cycle pulse.
- `btn_back` input 1: single-cycle pulse.
- `key_pickup` input 1: pulse when the player collects a key.
- `player_hit` input 1: pulse on player/boss or player/hazard collision.
- `at_door` input 1: level, high while the player overlaps the door.
- `boss_defeated` input 1: pulse, meaningful in STAGE3 only.
- `state` output 4: current screen.
- `life` output 2: remaining lives.
- `key_find` output 2: keys held, 0–3.
- `todo` output 2: objective hint.
- `play_valid` output 4: cleared-stage mask.
- `isDark` output 1: STAGE2 lights-off flag.

## Operation
- State encodings: TITLE=0, STAFF=1, STAGE1=2, SUCCESS1=3, STAGE2=4, SUCCESS2=5, STAGE3=6, SUCCESS3=7, FAIL=8, HELP=9. Codes 10–15 are illegal and return to TITLE on the next cycle.
- TITLE:
  - `btn_start` goes to STAGE1 and loads `life`=LIFE_INIT.
  - `btn_help` goes to HELP.
  - `btn_back` goes to STAFF.
  - Priority when pulses coincide: start > help > back.
- STAFF and HELP: `btn_back` goes to TITLE. All other inputs are ignored.
- Stage entry (into any STAGEn):
  - Clears `key_find`, the invulnerability counter and the dark counter.
  - Clears `isDark`.
  - `life` carries over from the previous stage.
- In STAGEn, `key_pickup` increments `key_find`, saturating at 3.
- Exit from STAGE1/STAGE2: `at_door` while the registered `key_find`==3 goes to SUCCESS1/SUCCESS2.
- Exit from STAGE3: `boss_defeated` goes to SUCCESS3. Keys are not required.
- `btn_back` in any stage aborts to TITLE.
- `player_hit` while invulnerability is 0:
  - Decrements `life` and loads invulnerability with INVULN_FRAMES.
  - If `life` was 1, `life` becomes 0 and the state goes to FAIL.
  - While invulnerability is non-zero, hits are ignored.
- Priority within a stage for same-cycle events: FAIL > back-abort > success exit > key increment.
  - A `key_pickup` coinciding with `at_door` is counted, but that cycle's exit test sees the old count.
- SUCCESSn:
  - Entry sets `play_valid[n]`.
  - After SUCCESS_FRAMES frame ticks, or on an earlier `btn_start`, the state advances. SUCCESS1 goes to STAGE2, SUCCESS2 to STAGE3, SUCCESS3 to TITLE.
- FAIL:
  - After FAIL_FRAMES ticks the state goes to TITLE. Buttons are ignored.
  - `play_valid` is kept and is cleared only by reset.
- `todo` values:
  - 0: in STAGE1/STAGE2 with `key_find`<3.
  - 1: in STAGE1/STAGE2 with `key_find`==3.
  - 2: in STAGE3.
  - 3: otherwise.
- `isDark` toggles on every DARK_PERIOD-th frame tick in STAGE2. It is 0 in every other state.

## Timing
- All outputs are registered. Every response appears on the cycle after the causing input pulse.
- Frame counters:
  - Advance only on `frame_tick`.
  - Are loaded on entry to the timed state.
  - A hold of N frames expires on the N-th `frame_tick` after entry, and the transition follows one cycle later.
- Invulnerability decrements on `frame_tick`, saturating at 0.
- Reset values (asynchronous; reset may assert mid-stage or mid-timer):
  - `state`=TITLE, `life`=LIFE_INIT, `key_find`=0.
  - `play_valid`=4'b0001, `todo`=3, `isDark`=0.
  - All counters are 0.
- Counter widths are sized by $clog2 of the largest parameter plus 1. No wrap-around is permitted.

## Structure
- Shared package `game_pkg`:
  - The 4-bit state codes listed above. `game_display` uses the same codes.
  - The `todo` codes.
  - LIFE_MAX=3.
- Sub-module `frame_timer`:
  - Instantiated three times: hold timer, invulnerability timer, dark timer.
  - Ports: `load`, `load_val`, `frame_tick`, `count`, `done`, where `done` is a level that is high while `count`==0.
- The FSM plus counters lands at roughly 200–300 lines.

## Test plan
- Reset mid-STAGE2 with `isDark`=1: `rst_n` low gives `state`=0, `isDark`=0, `play_valid`=0001 asynchronously.
- TITLE `btn_start`, then 3×`key_pickup` and a 4th pulse, then `at_door` → `key_find` saturates at 3, `todo` goes 0→1, `state` goes 2→3 one cycle after `at_door`, `play_valid`=0011.
- SUCCESS1 with no button → exactly 180 frame ticks later `state`=4. Repeat with `btn_start` at tick 10 → `state`=4 immediately.
- STAGE1 with `life`=3: 3 hits 10 frames apart → only the first counts, `life`=2. Hits at 0, 61 and 122 frames → `life`=0, `state`=8, then TITLE after 240 ticks.
- Same-cycle `player_hit` (last life) and `at_door` with 3 keys → `state`=8, not SUCCESS.
- STAGE2 → `isDark` toggles at ticks 120 and 240. Write illegal state 12 by force → next cycle `state`=0.
